// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_seq_pkg;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } pc_seq_state_e;

endpackage

// File: rtl/pc_seq_perf.sv
// Free-running event counters for the fetch sequencer; each wraps silently at 2^32.
module pc_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_evt,
    input  logic        stall_evt,
    input  logic        flush_evt,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_evt};
        stall_cnt_d = stall_cnt_q + {31'd0, stall_evt};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_evt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: issues imem requests, buffers one instruction for decode, applies traps/redirects.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     fetch_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            misaligned_exc,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    output pc_seq_state_e   dbg_state
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

    pc_seq_state_e   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]     fetch_instr_q, fetch_instr_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            misaligned_q, misaligned_d;

    logic            redir_misaligned;
    logic            take_redir;
    logic            flush;
    logic [XLEN-1:0] flush_target;

    // Memory handshake: a request (imem_req=1) holds its address until the cycle imem_ack is seen;
    // that cycle completes it. Decode takes the buffered word in any cycle with fetch_valid && !stall.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            REQ:     imem_req = 1'b1;
            HOLD:    imem_req = !stall;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: imem_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;
        fetch_valid_d = fetch_valid_q;

        redir_misaligned = (redirect_target & ~ALIGN_MASK) != '0;
        take_redir       = redirect_valid && !trap_valid && !redir_misaligned;
        misaligned_d     = redirect_valid && !trap_valid && redir_misaligned;
        flush            = trap_valid || take_redir;
        flush_target     = trap_valid ? (trap_vector & ALIGN_MASK) : redirect_target;

        if (flush) begin
            pc_d          = flush_target;
            fetch_valid_d = 1'b0;
            // An unacknowledged request must still complete; its data is dropped in DRAIN.
            if (state_q == DRAIN) begin
                state_d = imem_ack ? REQ : DRAIN;
            end else if (imem_req && !imem_ack) begin
                state_d      = DRAIN;
                drain_addr_d = imem_addr;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        fetch_instr_d = imem_rdata;
                        fetch_pc_d    = pc_q;
                        fetch_valid_d = 1'b1;
                        pc_d          = pc_q + STEP;
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (imem_ack) begin
                            fetch_instr_d = imem_rdata;
                            fetch_pc_d    = pc_q;
                            fetch_valid_d = 1'b1;
                            pc_d          = pc_q + STEP;
                        end else begin
                            fetch_valid_d = 1'b0;
                            state_d       = REQ;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            drain_addr_q  <= RESET_VECTOR;
            fetch_pc_q    <= RESET_VECTOR;
            fetch_instr_q <= '0;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_valid_q <= fetch_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign fetch_valid    = fetch_valid_q;
    assign fetch_pc       = fetch_pc_q;
    assign fetch_instr    = fetch_instr_q;
    assign misaligned_exc = misaligned_q;
    assign dbg_state      = state_q;

`ifdef PC_SEQ_PERF_EN
    pc_seq_perf u_perf (
        .clk            (clk),
        .rst            (reset),
        .fetch_evt      (fetch_valid_q && !stall),
        .stall_evt      (fetch_valid_q && stall),
        .flush_evt      (flush),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: completed requests and consumed instructions are scoreboarded.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack_en;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;

    logic        imem_req, imem_ack, fetch_valid, misaligned_exc;
    logic [31:0] imem_addr, imem_rdata, fetch_pc, fetch_instr;
    pc_seq_state_e dbg_state;

    logic        imem_req_b, imem_ack_b, fetch_valid_b, misaligned_exc_b;
    logic [31:0] imem_addr_b, imem_rdata_b, fetch_pc_b, fetch_instr_b;
    pc_seq_state_e dbg_state_b;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] pf_a, ps_a, pl_a, pf_b, ps_b, pl_b;
`endif

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_fetch_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int mis_seen = 0;

    always #5 clk = ~clk;

    // Memory model: ack gated by ack_en; data encodes the address.
    assign imem_ack     = imem_req && ack_en;
    assign imem_rdata   = {imem_addr[23:0], 8'h13};
    assign imem_ack_b   = imem_req_b;
    assign imem_rdata_b = {imem_addr_b[23:0], 8'h13};

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .misaligned_exc(misaligned_exc),
`ifdef PC_SEQ_PERF_EN
        .perf_fetch_cnt(pf_a), .perf_stall_cnt(ps_a), .perf_flush_cnt(pl_a),
`endif
        .dbg_state(dbg_state)
    );

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(rst),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
        .fetch_valid(fetch_valid_b), .fetch_pc(fetch_pc_b), .fetch_instr(fetch_instr_b),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_target(32'h0),
        .trap_valid(1'b0), .trap_vector(32'h0), .misaligned_exc(misaligned_exc_b),
`ifdef PC_SEQ_PERF_EN
        .perf_fetch_cnt(pf_b), .perf_stall_cnt(ps_b), .perf_flush_cnt(pl_b),
`endif
        .dbg_state(dbg_state_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] instr);
        exp_fetch_q.push_back({pc, instr});
    endtask

    task automatic drive(input logic s, input logic a, input logic r_v, input logic [31:0] r_t,
                         input logic t_v, input logic [31:0] t_vec);
        @(negedge clk);
        stall           = s;
        ack_en          = a;
        redirect_valid  = r_v;
        redirect_target = r_t;
        trap_valid      = t_v;
        trap_vector     = t_vec;
        #2;
    endtask

    task automatic idle_in(input logic s, input logic a);
        drive(s, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever a request completes or decode consumes a word.
    always @(negedge clk) begin
        logic [63:0] e;
        #3;
        if (!rst) begin
            if (imem_req && imem_ack) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = 64'(exp_req_q.pop_front());
                    chk("req_addr", 64'(imem_addr), e);
                end
            end
            if (fetch_valid && !stall) begin
                if (exp_fetch_q.size() == 0) begin
                    chk("fetch_unexpected", {fetch_pc, fetch_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_fetch_q.pop_front();
                    chk("fetch_pc_instr", {fetch_pc, fetch_instr}, e);
                end
            end
            if (misaligned_exc) mis_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; ack_en = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; trap_valid = 1'b0; trap_vector = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'h0);
        chk("rst_fv", 64'(fetch_valid), 64'd0);
        chk("rst_fpc", 64'(fetch_pc), 64'h0);
        chk("rst_instr", 64'(fetch_instr), 64'h0);
        chk("rst_mis", 64'(misaligned_exc), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_fpc_b", 64'(fetch_pc_b), 64'hFFFF_FFFC);

        @(negedge clk); rst = 1'b0; #2;
        chk("idle_req", 64'(imem_req), 64'd0);
        chk("idle_state", 64'(dbg_state), 64'(IDLE));
        chk("idle_req_b", 64'(imem_req_b), 64'd0);

        // Zero-wait sequential fetch
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_fetch(32'h0, 32'h0000_0013); push_fetch(32'h4, 32'h0000_0413);
        idle_in(1'b0, 1'b1);
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'h0);
        chk("first_addr_b", 64'(imem_addr_b), 64'hFFFF_FFFC);
        idle_in(1'b0, 1'b1);
        chk("first_fv", 64'(fetch_valid), 64'd1);
        chk("first_instr", 64'(fetch_instr), 64'h13);
        chk("second_addr", 64'(imem_addr), 64'h4);
        chk("wrap_addr_b", 64'(imem_addr_b), 64'h0);
        chk("wrap_fpc_b", 64'(fetch_pc_b), 64'hFFFF_FFFC);
        idle_in(1'b0, 1'b1);
        chk("third_addr", 64'(imem_addr), 64'h8);
        chk("wrap_next_b", 64'(imem_addr_b), 64'h4);

        // Stall for three cycles
        push_fetch(32'h8, 32'h0000_0813); push_req(32'hC);
        idle_in(1'b1, 1'b1);
        chk("stall_req", 64'(imem_req), 64'd0);
        idle_in(1'b1, 1'b1);
        idle_in(1'b1, 1'b1);
        chk("stall_req3", 64'(imem_req), 64'd0);
        chk("stall_fpc", 64'(fetch_pc), 64'h8);
        chk("stall_instr", 64'(fetch_instr), 64'h813);
        chk("stall_fv", 64'(fetch_valid), 64'd1);
        idle_in(1'b0, 1'b1);
        chk("resume_addr", 64'(imem_addr), 64'hC);

        // Redirect with a pending request -> DRAIN
        push_fetch(32'hC, 32'h0000_0C13); push_req(32'h10); push_req(32'h100);
        idle_in(1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("pend_addr", 64'(imem_addr), 64'h10);
        idle_in(1'b0, 1'b0);
        chk("drain_req", 64'(imem_req), 64'd1);
        chk("drain_addr", 64'(imem_addr), 64'h10);
        chk("drain_fv", 64'(fetch_valid), 64'd0);
        chk("drain_state", 64'(dbg_state), 64'(DRAIN));
        idle_in(1'b0, 1'b1);
        idle_in(1'b0, 1'b1);
        chk("redir_addr", 64'(imem_addr), 64'h100);

        // Trap beats a same-cycle redirect; vector low bits cleared
        push_req(32'h200); push_req(32'h204); push_fetch(32'h200, 32'h0002_0013);
        drive(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h203);
        idle_in(1'b0, 1'b1);
        chk("trap_fv", 64'(fetch_valid), 64'd0);
        chk("trap_addr", 64'(imem_addr), 64'h200);
        idle_in(1'b0, 1'b1);

        // Misaligned redirect is ignored with a one-cycle exception pulse
        push_fetch(32'h204, 32'h0002_0413); push_fetch(32'h208, 32'h0002_0813);
        push_fetch(32'h20C, 32'h0002_0C13);
        push_req(32'h208); push_req(32'h20C); push_req(32'h210);
        drive(1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
        chk("mis_before", 64'(misaligned_exc), 64'd0);
        idle_in(1'b0, 1'b1);
        chk("mis_pulse", 64'(misaligned_exc), 64'd1);
        idle_in(1'b0, 1'b1);
        chk("mis_after", 64'(misaligned_exc), 64'd0);

        // Redirect inside DRAIN only updates the PC
        push_fetch(32'h210, 32'h0002_1013); push_fetch(32'h500, 32'h0005_0013);
        push_req(32'h214); push_req(32'h500);
        idle_in(1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        chk("drain2_state", 64'(dbg_state), 64'(DRAIN));
        chk("drain2_addr", 64'(imem_addr), 64'h214);
        idle_in(1'b0, 1'b1);
        idle_in(1'b0, 1'b1);
        chk("drain2_next", 64'(imem_addr), 64'h500);
        idle_in(1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);

        // Asynchronous reset while in DRAIN
        @(negedge clk);
        redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_addr", 64'(imem_addr), 64'h0);
        chk("mid_rst_fv", 64'(fetch_valid), 64'd0);
        chk("mid_rst_fpc", 64'(fetch_pc), 64'h0);
        chk("mid_rst_instr", 64'(fetch_instr), 64'h0);
        chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));

        push_req(32'h0); push_req(32'h4); push_fetch(32'h0, 32'h0000_0013);
        @(negedge clk); ack_en = 1'b1; stall = 1'b0; rst = 1'b0; #2;
        idle_in(1'b0, 1'b1);
        chk("post_rst_addr", 64'(imem_addr), 64'h0);
        idle_in(1'b0, 1'b1);
        idle_in(1'b1, 1'b1);
        chk("post_rst_fpc", 64'(fetch_pc), 64'h4);
        idle_in(1'b1, 1'b1);
        idle_in(1'b1, 1'b1);

        chk("req_q_left", 64'(exp_req_q.size()), 64'd0);
        chk("fetch_q_left", 64'(exp_fetch_q.size()), 64'd0);
        chk("mis_pulses", 64'(mis_seen), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that owns the fetch PC and sequences instruction fetch: it issues requests to instruction memory, buffers one returned instruction for decode, and applies trap and branch/jump redirects. It sits between the PC register datapath, the instruction memory port and the decode stage. It replaces free-running "PC+4 every clock" behaviour with a stall- and redirect-aware sequence.

Parameters:
XLEN, 32, datapath and address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction memory request valid
imem_addr  out  XLEN  request address; equals current fetch PC
imem_ack  in  1  memory response valid; may arrive in the same cycle as imem_req
imem_rdata  in  32  instruction word, valid with imem_ack
fetch_valid  out  1  buffered instruction valid to decode
fetch_pc  out  XLEN  PC of buffered instruction
fetch_instr  out  32  buffered instruction word
stall  in  1  decode not ready; the buffer is consumed when fetch_valid && !stall
redirect_valid  in  1  branch/jump taken
redirect_target  in  XLEN  branch/jump target
trap_valid  in  1  trap entry
trap_vector  in  XLEN  trap target; bits [1:0] forced to 0
misaligned_exc  out  1  one-cycle pulse when a redirect target is not 4-byte aligned

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: pc=RESET_VECTOR, state=IDLE, imem_req=0, fetch_valid=0, fetch_pc=RESET_VECTOR, fetch_instr=0, misaligned_exc=0.
- Reset mid-operation: immediate return to reset values; any outstanding request is abandoned.
- FSM states: IDLE, REQ, HOLD, DRAIN.
- IDLE: imem_req=0. Always goes to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc.
  - On imem_ack: fetch_instr<=imem_rdata, fetch_pc<=pc, fetch_valid<=1, pc<=pc+4, then HOLD.
  - Without imem_ack: stay in REQ; request and address held stable.
- HOLD: fetch_valid=1.
  - stall=1: imem_req=0; stay in HOLD; fetch outputs stable.
  - stall=0: buffer consumed; imem_req=1 this cycle.
    - With imem_ack: reload buffer as in REQ, pc+=4, stay in HOLD. Zero-wait memory gives one instruction per cycle.
    - Without imem_ack: fetch_valid<=0, go to REQ.
- Request rule: once imem_req is asserted it stays asserted with an unchanged imem_addr until imem_ack.
- Redirect priority: trap > redirect > sequential. A redirect is evaluated in any non-IDLE state.
- Accepted redirect/trap:
  - pc<=target; fetch_valid<=0, which also applies if the buffer is being consumed that cycle.
  - If imem_req=1 and imem_ack=0 that cycle: go to DRAIN.
  - Otherwise go to REQ; a same-cycle ack is discarded.
- DRAIN: imem_req=1 with the stale address. On imem_ack the data is discarded and the state goes to REQ using the new pc. A further redirect in DRAIN updates pc only.
- Misaligned redirect (redirect_target[1:0]!=0 with trap_valid=0): the redirect is ignored, misaligned_exc=1 for the next cycle, and sequencing continues unchanged.
- Arithmetic: pc+4 is modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0x0000_0000.
- redirect_valid/trap_valid in IDLE: trap or aligned redirect loads pc and the state still goes to REQ.

Optional Feature:
PC_SEQ_PERF_EN: when defined, the block adds three 32-bit output counters, each reset to 0 and wrapping silently:
- perf_fetch_cnt: increments on each consumed instruction.
- perf_stall_cnt: increments each cycle with fetch_valid && stall.
- perf_flush_cnt: increments on each accepted redirect or trap.
When undefined, the ports and logic are absent and the block behaves identically otherwise.

Decomposition:
- Package pc_seq_pkg: state enum type (IDLE, REQ, HOLD, DRAIN), INSTR_BYTES=4 constant, default XLEN and RESET_VECTOR constants.
- Sub-module pc_seq_perf holds the counters. It is instantiated only under PC_SEQ_PERF_EN and fed single-bit event strobes.

Test Plan:
1. Reset; RESET_VECTOR=0; zero-wait memory returning 0x00000013 -> one IDLE cycle; imem_req=1 with addr 0x0; next cycle fetch_valid=1, fetch_pc=0x0, fetch_instr=0x13; then addr 0x4, 0x8 on successive cycles.
2. stall=1 for 3 cycles while fetch_valid=1 -> imem_req=0; fetch_pc and fetch_instr stable; the fetch resumes at the next sequential address the cycle stall falls.
3. Request to 0x8 pending with no ack; redirect to 0x100 -> imem_req held at 0x8 until ack; that data is never presented; next request addr 0x100.
4. Same-cycle trap_valid (vector 0x203) and redirect_valid (0x300) -> next request addr 0x200; fetch_valid=0.
5. Redirect to 0x102 -> misaligned_exc high exactly one cycle; next fetch address unchanged sequential value.
6. RESET_VECTOR=0xFFFFFFFC -> first address 0xFFFFFFFC, second 0x00000000. Also assert reset mid-DRAIN -> all outputs return to reset values immediately.
